// File: rtl/ones_frame_pkg.sv
// ----------------------------------------------------------------------------
// ones_frame_pkg
// Shared definitions for the two-ones framed serial link. The transmitter
// (ones_frame_tx) and the downstream "11" detector both import this package
// so that the state encoding and the line-level bit values stay in agreement.
//
// Contents:
//   state_t    - 3-bit transmitter state encoding
//   SYNC_BIT   - line value during both sync cycles
//   SEP_BIT    - line value in the separator cycle after the sync
//   STUFF_BIT  - line value in a stuff cycle that follows every payload '1'
//   IDLE_BIT   - line value while no frame is being sent
// ----------------------------------------------------------------------------
package ones_frame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SYNC1 = 3'd1,
      ST_SYNC2 = 3'd2,
      ST_SEP   = 3'd3,
      ST_DATA  = 3'd4,
      ST_STUFF = 3'd5
   } state_t;

   // The sync "11" is the only place two consecutive ones may appear; the
   // separator and stuff zeros guarantee that for any payload.
   localparam logic SYNC_BIT  = 1'b1;
   localparam logic SEP_BIT   = 1'b0;
   localparam logic STUFF_BIT = 1'b0;
   localparam logic IDLE_BIT  = 1'b0;

endpackage : ones_frame_pkg

// File: rtl/ones_frame_if.sv
// ----------------------------------------------------------------------------
// ones_frame_if
// Request/line bundle between a frame source and the ones_frame_tx block.
//
// Signals:
//   start  - request to send one frame (source -> tx)
//   data   - payload, DATA_W bits      (source -> tx)
//   w      - serial line               (tx -> source/line)
//   busy   - frame on the line         (tx -> source)
//   done   - final bit of a frame      (tx -> source)
//
// Modports:
//   master - the frame source side
//   slave  - the transmitter side
// ----------------------------------------------------------------------------
interface ones_frame_if #(
   parameter int DATA_W = 8
) ();

   logic              start;
   logic [DATA_W-1:0] data;
   logic              w;
   logic              busy;
   logic              done;

   modport master (
      output start,
      output data,
      input  w,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  data,
      output w,
      output busy,
      output done
   );

endinterface : ones_frame_if

// File: rtl/ones_frame_piso.sv
// ----------------------------------------------------------------------------
// ones_frame_piso
// Parallel-load, MSB-first shift-left payload register. The bit currently on
// offer is always the MSB; each shift brings the next lower bit up and fills
// the bottom with zero.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, clears the register
//   load  - capture din (has priority over shift)
//   shift - advance to the next payload bit
//   din   - parallel payload input
//   msb   - current payload bit
// ----------------------------------------------------------------------------
module ones_frame_piso #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] din,
   output logic              msb
);

   logic [DATA_W-1:0] sr;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr <= '0;
      end else if (load) begin
         sr <= din;
      end else if (shift) begin
         sr <= {sr[DATA_W-2:0], 1'b0};
      end
   end

   assign msb = sr[DATA_W-1];

endmodule : ones_frame_piso

// File: rtl/ones_frame_tx.sv
// ----------------------------------------------------------------------------
// ones_frame_tx
// Serial frame transmitter for a two-ones detector link. A frame is
//   SYNC1(1) SYNC2(1) SEP(0) then the payload MSB first, with one stuff zero
// inserted after every payload '1', so "11" occurs only as the sync.
// Frame length is 3 + DATA_W + popcount(data) cycles; at least one idle
// (w=0) cycle separates consecutive frames.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset; aborts any frame in flight
//   bus.start  - frame request, sampled only in IDLE
//   bus.data   - payload, captured on the accepting edge
//   bus.w      - serial line (decoded from registered state)
//   bus.busy   - high from SYNC1 through the final frame bit
//   bus.done   - one-cycle pulse on the final frame bit
// ----------------------------------------------------------------------------
module ones_frame_tx #(
   parameter int DATA_W = 8
) (
   input  logic          clk,
   input  logic          rst,
   ones_frame_if.slave   bus
);

   import ones_frame_pkg::*;

   localparam int                CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DATA_W - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             load;
   logic             shift;
   logic             cur_bit;
   logic             last;

   ones_frame_piso #(
      .DATA_W (DATA_W)
   ) u_piso (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (shift),
      .din   (bus.data),
      .msb   (cur_bit)
   );

   // cnt holds the index of the payload bit currently being sent.
   assign last = (cnt == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic. The payload register advances when a bit is finished:
   // directly from DATA for a '0', or from the following STUFF for a '1'.
   // NOTE: every signal driven here gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      load      = 1'b0;
      shift     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               state_nxt = ST_SYNC1;
               load      = 1'b1;
               cnt_nxt   = '0;
            end
         end
         ST_SYNC1: state_nxt = ST_SYNC2;
         ST_SYNC2: state_nxt = ST_SEP;
         ST_SEP:   state_nxt = ST_DATA;
         ST_DATA: begin
            if (cur_bit) begin
               state_nxt = ST_STUFF;
            end else begin
               shift = 1'b1;
               if (last) begin
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_DATA;
                  cnt_nxt   = cnt + 1'b1;
               end
            end
         end
         ST_STUFF: begin
            shift = 1'b1;
            if (last) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_DATA;
               cnt_nxt   = cnt + 1'b1;
            end
         end
         default: begin
            // Unused encodings recover to IDLE on the next edge.
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Moore output decode from registered state, counter and payload MSB.
   always_comb begin
      bus.w    = IDLE_BIT;
      bus.busy = 1'b0;
      bus.done = 1'b0;
      case (state)
         ST_SYNC1, ST_SYNC2: begin
            bus.w    = SYNC_BIT;
            bus.busy = 1'b1;
         end
         ST_SEP: begin
            bus.w    = SEP_BIT;
            bus.busy = 1'b1;
         end
         ST_DATA: begin
            bus.w    = cur_bit;
            bus.busy = 1'b1;
            // A final '0' ends the frame here; a final '1' ends in STUFF.
            bus.done = ~cur_bit & last;
         end
         ST_STUFF: begin
            bus.w    = STUFF_BIT;
            bus.busy = 1'b1;
            bus.done = last;
         end
         default: begin
            bus.w    = IDLE_BIT;
            bus.busy = 1'b0;
            bus.done = 1'b0;
         end
      endcase
   end

endmodule : ones_frame_tx

// File: tb/tb_ones_frame_tx.sv
// ----------------------------------------------------------------------------
// tb_ones_frame_tx
// Self-checking bench for ones_frame_tx. Each accepted frame pushes its full
// expected line sequence (w/busy/done plus the expected "11" detection) onto a
// scoreboard queue; every cycle pops one entry (or expects idle when the queue
// is empty) and compares it with the DUT and a two-ones detector model.
// ----------------------------------------------------------------------------
module tb_ones_frame_tx;

   localparam int DATA_W = 8;

   typedef struct packed {
      logic w;
      logic busy;
      logic done;
      logic det;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ones_frame_if #(.DATA_W(DATA_W)) bus ();

   ones_frame_tx #(
      .DATA_W (DATA_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   checks      = 0;
   int   failures    = 0;
   int   cyc         = 0;
   int   det_count   = 0;
   int   frames_sent = 0;
   logic prev_w      = 1'b0;

   function automatic exp_t mk(input logic lw, input logic ldone, input logic ldet);
      exp_t e;
      e.w    = lw;
      e.busy = 1'b1;
      e.done = ldone;
      e.det  = ldet;
      return e;
   endfunction

   // Build the expected frame: sync 1,1, separator 0, then payload MSB first
   // with a 0 after every 1; done on the very last entry; detection on SYNC2.
   task automatic push_frame(input logic [DATA_W-1:0] d);
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b1));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0));
      for (int i = DATA_W - 1; i >= 0; i--) begin
         if (d[i]) begin
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0));
            exp_q.push_back(mk(1'b0, i == 0, 1'b0));
         end else begin
            exp_q.push_back(mk(1'b0, i == 0, 1'b0));
         end
      end
      frames_sent++;
   endtask

   // One cycle: check the outputs of the current cycle at the falling edge,
   // then drive the inputs for the next rising edge and update the model.
   task automatic tick(input logic s, input logic [DATA_W-1:0] d, input logic r);
      exp_t e;
      logic det_obs;
      bit   idle_now;
      @(negedge clk);
      if (exp_q.size() > 0) begin
         e        = exp_q.pop_front();
         idle_now = 1'b0;
      end else begin
         e        = '0;
         idle_now = 1'b1;
      end
      det_obs = prev_w & bus.w;
      prev_w  = bus.w;
      if (det_obs === 1'b1) det_count++;

      checks++;
      assert ({bus.w, bus.busy, bus.done} === {e.w, e.busy, e.done}) else begin
         failures++;
         $error("FAIL line cyc=%0d w/busy/done got=%b exp=%b",
                cyc, {bus.w, bus.busy, bus.done}, {e.w, e.busy, e.done});
      end
      checks++;
      assert (det_obs === e.det) else begin
         failures++;
         $error("FAIL det cyc=%0d got=%b exp=%b", cyc, det_obs, e.det);
      end

      rst       = r;
      bus.start = s;
      bus.data  = d;
      if (r) begin
         exp_q.delete();
      end else if (idle_now && s) begin
         push_frame(d);
      end
      cyc++;
   endtask

   initial begin
      bus.start = 1'b0;
      bus.data  = '0;

      // Reset state, then reset winning over a simultaneous start.
      tick(1'b0, 8'h00, 1'b1);
      tick(1'b1, 8'hA5, 1'b1);
      tick(1'b0, 8'h00, 1'b0);
      tick(1'b0, 8'h00, 1'b0);

      // 8'hA5: 15-cycle frame; data changes after acceptance are ignored.
      tick(1'b1, 8'hA5, 1'b0);
      repeat (17) tick(1'b0, 8'h3C, 1'b0);

      // 8'h00: 11-cycle frame.
      tick(1'b1, 8'h00, 1'b0);
      repeat (13) tick(1'b0, 8'hFF, 1'b0);

      // 8'hFF: 19-cycle frame of "10" pairs after the sync.
      tick(1'b1, 8'hFF, 1'b0);
      repeat (21) tick(1'b0, 8'h00, 1'b0);

      // start held high: back-to-back 13-cycle frames, one idle between.
      repeat (45) tick(1'b1, 8'h81, 1'b0);
      repeat (16) tick(1'b0, 8'h00, 1'b0);

      // Reset during cycle 6 of an 8'hA5 frame, then a clean frame.
      tick(1'b1, 8'hA5, 1'b0);
      repeat (5) tick(1'b0, 8'hA5, 1'b0);
      tick(1'b0, 8'hA5, 1'b1);
      repeat (3) tick(1'b0, 8'h00, 1'b0);
      tick(1'b1, 8'hA5, 1'b0);
      repeat (17) tick(1'b0, 8'h00, 1'b0);

      // Exactly one "11" per started frame, including the aborted one
      // (its sync had already gone out).
      checks++;
      assert (det_count == frames_sent) else begin
         failures++;
         $error("FAIL det_total got=%0d exp=%0d", det_count, frames_sent);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_ones_frame_tx
